// File: rtl/sopc_v3_pio_pkg.sv
// Shared constants for the SOPC v3 PIO slaves: register offsets and
// edge-capture mode encodings.
package sopc_v3_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sopc_v3_debounce_bit.sv
// One field input: 2-flop synchroniser, 2-entry tick-sampled history and
// the debounced level, which moves only after three equal tick samples.
module sopc_v3_debounce_bit (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic       sync_meta;
  logic       sync_q;
  logic [1:0] hist;

  // The debounced level follows the synchronised input only when the
  // current tick sample agrees with both earlier tick samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      hist      <= 2'b00;
      dout      <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
      if (tick) begin
        hist <= {hist[0], sync_q};
        if ((sync_q == hist[0]) && (sync_q == hist[1]) && (sync_q != dout))
          dout <= sync_q;
      end
    end
  end

endmodule

// File: rtl/sopc_v3_sens_in.sv
// Avalon-MM sensor input PIO: debounced field inputs with per-bit edge
// capture (write-one-to-clear) and a maskable level interrupt.
module sopc_v3_sens_in
  import sopc_v3_pio_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int EDGE_TYPE  = 0,
  parameter int PERIOD_W   = 16,
  parameter int PERIOD_RST = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] count;
  logic                tick;
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    data_prev;
  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    edge_cap;
  logic [WIDTH-1:0]    edge_hit;
  logic [WIDTH-1:0]    cap_clr;
  logic                wr_en;
  logic                rd_en;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign tick         = (count == period);
  assign cap_clr      = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign irq          = |(edge_cap & irq_mask);
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sopc_v3_debounce_bit u_debounce (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .din   (in_port[i]),
      .dout  (data[i])
    );
  end

  always_comb begin
    edge_hit = data & ~data_prev;
    if (EDGE_TYPE == EDGE_FALL)
      edge_hit = ~data & data_prev;
    else if (EDGE_TYPE == EDGE_ANY)
      edge_hit = data ^ data_prev;
  end

  // A new edge is OR-ed in after the clear so it survives a simultaneous
  // write-one-to-clear of the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      period    <= PERIOD_W'(PERIOD_RST);
      count     <= '0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      data_prev <= '0;
      readdata  <= 32'd0;
    end else begin
      data_prev <= data;
      edge_cap  <= (edge_cap & ~cap_clr) | edge_hit;

      if (wr_en && address == ADDR_PERIOD) begin
        period <= writedata[PERIOD_W-1:0];
        count  <= '0;
      end else if (tick) begin
        count <= '0;
      end else begin
        count <= count + PERIOD_W'(1);
      end

      if (wr_en && address == ADDR_IRQMASK)
        irq_mask <= writedata[WIDTH-1:0];

      readdata <= 32'd0;
      if (rd_en) begin
        case (address)
          ADDR_DATA:    readdata <= 32'(data);
          ADDR_PERIOD:  readdata <= 32'(period);
          ADDR_IRQMASK: readdata <= 32'(irq_mask);
          ADDR_EDGECAP: readdata <= 32'(edge_cap);
          default:      readdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sopc_v3_sens_in.sv
// Bench for sopc_v3_sens_in: a rising-edge and an any-edge build share
// stimulus and are checked against a run-length reference model.
module tb_sopc_v3_sens_in;
  import sopc_v3_pio_pkg::*;

  localparam int W    = 4;
  localparam int PW   = 16;
  localparam int PRST = 50000;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          read_n;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_any;
  logic          irq_rise, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sopc_v3_sens_in #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .PERIOD_W(PW), .PERIOD_RST(PRST)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_rise), .in_port(in_port), .irq(irq_rise));

  sopc_v3_sens_in #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .PERIOD_W(PW), .PERIOD_RST(PRST)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_any), .in_port(in_port), .irq(irq_any));

  // Reference model: an input level is accepted once it has been seen on
  // three consecutive prescaler ticks (run length >= 3).
  int           m_period, m_cnt;
  int           m_run [W];
  logic [W-1:0] m_last, m_sync1, m_sync2, m_db, m_dbprev, m_mask;
  logic [W-1:0] m_cap_rise, m_cap_any;
  logic [31:0]  m_rd_rise, m_rd_any;

  always @(posedge clk) begin : model
    logic         tk;
    logic [W-1:0] db_new, clr;
    logic         wr, rd;
    if (reset) begin
      m_period = PRST; m_cnt = 0; m_last = '0; m_sync1 = '0; m_sync2 = '0;
      m_db = '0; m_dbprev = '0; m_mask = '0; m_cap_rise = '0; m_cap_any = '0;
      m_rd_rise = 0; m_rd_any = 0;
      for (int i = 0; i < W; i++) m_run[i] = 2;
    end else begin
      wr = chipselect && !write_n;
      rd = chipselect && !read_n;
      tk = (m_cnt == m_period);
      m_rd_rise = 0; m_rd_any = 0;
      if (rd) begin
        case (address)
          2'd0: begin m_rd_rise = 32'(m_db);   m_rd_any = 32'(m_db);   end
          2'd1: begin m_rd_rise = m_period;    m_rd_any = m_period;    end
          2'd2: begin m_rd_rise = 32'(m_mask); m_rd_any = 32'(m_mask); end
          default: begin m_rd_rise = 32'(m_cap_rise); m_rd_any = 32'(m_cap_any); end
        endcase
      end
      db_new = m_db;
      if (tk) begin
        for (int i = 0; i < W; i++) begin
          if (m_sync2[i] == m_last[i]) m_run[i] = (m_run[i] >= 3) ? 3 : m_run[i] + 1;
          else m_run[i] = 1;
          m_last[i] = m_sync2[i];
          if (m_run[i] >= 3) db_new[i] = m_last[i];
        end
      end
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap_rise = (m_cap_rise & ~clr) | (m_db & ~m_dbprev);
      m_cap_any  = (m_cap_any  & ~clr) | (m_db ^ m_dbprev);
      m_dbprev = m_db;
      m_db     = db_new;
      if (wr && address == 2'd1) begin m_period = int'(writedata[PW-1:0]); m_cnt = 0; end
      else if (tk) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_sync2 = m_sync1;
      m_sync1 = in_port;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    r0 = rd_rise; r1 = rd_any;
  endtask

  task automatic test_reset();
    logic [31:0] r0, r1;
    logic [31:0] exp_rst [4];
    exp_rst[0] = 0; exp_rst[1] = PRST; exp_rst[2] = 0; exp_rst[3] = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), r0, r1);
      checks += 2;
      if (r0 !== exp_rst[a]) begin errors++; $display("[TB] FAIL reset_rd_rise[%0d]: got %h expected %h", a, r0, exp_rst[a]); end
      if (r1 !== exp_rst[a]) begin errors++; $display("[TB] FAIL reset_rd_any[%0d]: got %h expected %h", a, r1, exp_rst[a]); end
    end
    checks += 2;
    if (irq_rise !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq_rise: got %b expected 0", irq_rise); end
    if (irq_any !== 1'b0)  begin errors++; $display("[TB] FAIL reset_irq_any: got %b expected 0", irq_any); end
  endtask

  task automatic test_debounce();
    logic [31:0] r0, r1;
    bus_write(2'd1, 32'd3);
    in_port[0] = 1'b1;
    bus_read(2'd0, r0, r1);
    checks++;
    if (r0 !== 32'h0) begin errors++; $display("[TB] FAIL early_data: got %h expected %h", r0, 32'h0); end
    repeat (20) @(negedge clk);
    bus_read(2'd0, r0, r1);
    checks += 2;
    if (r0 !== 32'h1) begin errors++; $display("[TB] FAIL debounced_data: got %h expected %h", r0, 32'h1); end
    if (r1 !== m_rd_any) begin errors++; $display("[TB] FAIL debounced_data_any: got %h expected %h", r1, m_rd_any); end
    bus_read(2'd3, r0, r1);
    checks += 3;
    if (r0 !== 32'h1) begin errors++; $display("[TB] FAIL edgecap_rise: got %h expected %h", r0, 32'h1); end
    if (r1 !== 32'h1) begin errors++; $display("[TB] FAIL edgecap_any: got %h expected %h", r1, 32'h1); end
    if (irq_rise !== 1'b0) begin errors++; $display("[TB] FAIL irq_unmasked: got %b expected 0", irq_rise); end
  endtask

  task automatic test_glitch();
    logic [31:0] r0, r1;
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (5) @(negedge clk);
    in_port[1] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(2'd0, r0, r1);
    checks++;
    if (r0 !== 32'h1) begin errors++; $display("[TB] FAIL glitch_data: got %h expected %h", r0, 32'h1); end
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h1) begin errors++; $display("[TB] FAIL glitch_edgecap_rise: got %h expected %h", r0, 32'h1); end
    if (r1 !== 32'h1) begin errors++; $display("[TB] FAIL glitch_edgecap_any: got %h expected %h", r1, 32'h1); end
  endtask

  task automatic test_irq();
    logic [31:0] r0, r1;
    bus_write(2'd2, 32'h3);
    checks += 2;
    if (irq_rise !== 1'b1) begin errors++; $display("[TB] FAIL irq_on_mask_rise: got %b expected 1", irq_rise); end
    if (irq_any !== 1'b1)  begin errors++; $display("[TB] FAIL irq_on_mask_any: got %b expected 1", irq_any); end
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h1) begin errors++; $display("[TB] FAIL w1c_zero_keeps: got %h expected %h", r0, 32'h1); end
    if (irq_rise !== 1'b1) begin errors++; $display("[TB] FAIL irq_after_w0: got %b expected 1", irq_rise); end
    bus_write(2'd3, 32'h1);
    checks += 2;
    if (irq_rise !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_w1c_rise: got %b expected 0", irq_rise); end
    if (irq_any !== 1'b0)  begin errors++; $display("[TB] FAIL irq_after_w1c_any: got %b expected 0", irq_any); end
    bus_read(2'd3, r0, r1);
    checks++;
    if (r0 !== 32'h0) begin errors++; $display("[TB] FAIL w1c_clears: got %h expected %h", r0, 32'h0); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r0, r1;
    bit found = 0;
    bus_write(2'd2, 32'h4);
    in_port[2] = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_db[2] && !m_dbprev[2]) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL collision_timeout: got no edge expected edge within 60 cycles"); end
    address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (irq_rise !== 1'b1) begin errors++; $display("[TB] FAIL collision_irq: got %b expected 1", irq_rise); end
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h4) begin errors++; $display("[TB] FAIL collision_cap_rise: got %h expected %h", r0, 32'h4); end
    if (r1 !== 32'h4) begin errors++; $display("[TB] FAIL collision_cap_any: got %h expected %h", r1, 32'h4); end
  endtask

  task automatic test_any_edge();
    logic [31:0] r0, r1;
    bus_write(2'd1, 32'd0);
    in_port[3] = 1'b1;
    repeat (10) @(negedge clk);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h0) begin errors++; $display("[TB] FAIL any_clear_rise: got %h expected %h", r0, 32'h0); end
    if (r1 !== 32'h0) begin errors++; $display("[TB] FAIL any_clear_any: got %h expected %h", r1, 32'h0); end
    in_port[3] = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h0) begin errors++; $display("[TB] FAIL fall_cap_rise: got %h expected %h", r0, 32'h0); end
    if (r1 !== 32'h8) begin errors++; $display("[TB] FAIL fall_cap_any: got %h expected %h", r1, 32'h8); end
    bus_write(2'd3, 32'h8);
    in_port[3] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd3, r0, r1);
    checks += 2;
    if (r0 !== 32'h8) begin errors++; $display("[TB] FAIL rise_cap_rise: got %h expected %h", r0, 32'h8); end
    if (r1 !== 32'h8) begin errors++; $display("[TB] FAIL rise_cap_any: got %h expected %h", r1, 32'h8); end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, r0, r1);
    checks += 2;
    if (r0 !== 32'hD) begin errors++; $display("[TB] FAIL data_write_ignored: got %h expected %h", r0, 32'hD); end
    if (r1 !== m_rd_any) begin errors++; $display("[TB] FAIL data_write_ignored_any: got %h expected %h", r1, m_rd_any); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r0, r1;
    logic [31:0] exp_rst [4];
    exp_rst[0] = 0; exp_rst[1] = PRST; exp_rst[2] = 0; exp_rst[3] = 0;
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'hF);
    in_port[1] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1; address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    checks += 2;
    if (rd_rise !== 32'h0) begin errors++; $display("[TB] FAIL midreset_readdata: got %h expected %h", rd_rise, 32'h0); end
    if (irq_rise !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq_rise); end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), r0, r1);
      checks += 2;
      if (r0 !== exp_rst[a]) begin errors++; $display("[TB] FAIL midreset_rd_rise[%0d]: got %h expected %h", a, r0, exp_rst[a]); end
      if (r1 !== exp_rst[a]) begin errors++; $display("[TB] FAIL midreset_rd_any[%0d]: got %h expected %h", a, r1, exp_rst[a]); end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int op;
    logic [1:0] waddr [3];
    waddr[0] = 2'd0; waddr[1] = 2'd2; waddr[2] = 2'd3;
    bus_write(2'd1, 32'($urandom_range(0, 2)));
    bus_write(2'd2, 32'($urandom_range(0, 15)));
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks += 4;
      if (irq_rise !== |(m_cap_rise & m_mask)) begin errors++; $display("[TB] FAIL rand_irq_rise@%0d: got %b expected %b", c, irq_rise, |(m_cap_rise & m_mask)); end
      if (irq_any !== |(m_cap_any & m_mask))   begin errors++; $display("[TB] FAIL rand_irq_any@%0d: got %b expected %b", c, irq_any, |(m_cap_any & m_mask)); end
      if (rd_rise !== m_rd_rise) begin errors++; $display("[TB] FAIL rand_rd_rise@%0d: got %h expected %h", c, rd_rise, m_rd_rise); end
      if (rd_any !== m_rd_any)   begin errors++; $display("[TB] FAIL rand_rd_any@%0d: got %h expected %h", c, rd_any, m_rd_any); end
      if (hold == 0) begin
        in_port[$urandom_range(0, W-1)] ^= 1'b1;
        hold = $urandom_range(1, 12);
      end
      hold--;
      chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = waddr[$urandom_range(0, 2)];
        writedata = $urandom;
      end else if (op <= 2) begin
        chipselect = 1'b1; read_n = 1'b0;
        address = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = 32'd0; in_port = '0;
    test_reset();
    test_debounce();
    test_glitch();
    test_irq();
    test_w1c_collision();
    test_any_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
